// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcode/funct, state, aluop and select encodings for the multicycle controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: controller <-> datapath bundle
// master (controller): reads opcode/funct/zero/mem_ready, drives enables, selects, illegal_op, dbg_state
// slave (datapath): the mirror view
interface mips_mc_control_if #(parameter int STATE_W = 4);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic mem_ready;
  logic pcen;
  logic iord;
  logic memread;
  logic memwrite;
  logic irwrite;
  logic memtoreg;
  logic regdst;
  logic regwrite;
  logic alusrca;
  logic [1:0] alusrcb;
  logic [3:0] alucontrol;
  logic [1:0] pcsrc;
  logic illegal_op;
  logic [STATE_W-1:0] dbg_state;
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, illegal_op, dbg_state
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, illegal_op, dbg_state
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: aluop + funct -> alucontrol, plus funct_valid for supported R-type functs
// aluop/funct in; alucontrol, funct_valid out (purely combinational)
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       funct_valid
);
  logic [3:0] fctl;
  always_comb begin
    fctl = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      F_ADD:   fctl = ALU_ADD;
      F_SUB:   fctl = ALU_SUB;
      F_AND:   fctl = ALU_AND;
      F_OR:    fctl = ALU_OR;
      F_SLT:   fctl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
    alucontrol = aluop == ALUOP_SUB ? ALU_SUB : aluop == ALUOP_FUNCT ? fctl : ALU_ADD;
  end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main controller (Moore FSM with memory ready handshake)
// clk, reset (sync, active-high); bus: master view of mips_mc_control_if
// ILLEGAL_TRAP=1 parks in HALT on an undecodable instruction, 0 treats it as a NOP
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0,
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic reset,
  mips_mc_control_if.master bus
);
  state_t state, dec_next;
  aluop_t aluop;
  logic [3:0] alu_ctl;
  logic funct_valid, pcwrite, branch, illegal;
  logic iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  mips_alu_decoder u_dec (
    .aluop(aluop),
    .funct(bus.funct),
    .alucontrol(alu_ctl),
    .funct_valid(funct_valid)
  );
  // FETCH here means "undecodable"; DECODE never legitimately returns to FETCH
  assign dec_next = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                    bus.opcode == OP_RTYPE ? (funct_valid ? S_EXEC : S_FETCH) :
                    bus.opcode == OP_BEQ ? S_BRANCH :
                    bus.opcode == OP_ADDI ? S_ADDIEX :
                    bus.opcode == OP_J ? S_JUMP : S_FETCH;
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else case (state)
      S_FETCH:  state <= bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state <= (dec_next == S_FETCH && ILLEGAL_TRAP) ? S_HALT : dec_next;
      S_MEMADR: state <= bus.opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state <= bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state <= bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state <= S_ALUWB;
      S_ADDIEX: state <= S_ADDIWB;
      S_HALT:   state <= S_HALT;
      default:  state <= S_FETCH;
    endcase
  end
  // Reset masks every output in the same cycle so no write can slip past the reset edge
  always_comb begin
    pcwrite = 1'b0;
    branch = 1'b0;
    illegal = 1'b0;
    iord = 1'b0;
    memread = 1'b0;
    memwrite = 1'b0;
    irwrite = 1'b0;
    memtoreg = 1'b0;
    regdst = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_B;
    aluop = ALUOP_ADD;
    pcsrc = PC_ALU;
    if (!reset) case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_4;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        illegal = dec_next == S_FETCH;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord = 1'b1;
        memread = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        branch = 1'b1;
        pcsrc = PC_ALUOUT;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc = PC_JUMP;
      end
      default: ;
    endcase
  end
  assign bus.pcen = pcwrite | (branch & bus.zero);
  assign bus.iord = iord;
  assign bus.memread = memread;
  assign bus.memwrite = memwrite;
  assign bus.irwrite = irwrite;
  assign bus.memtoreg = memtoreg;
  assign bus.regdst = regdst;
  assign bus.regwrite = regwrite;
  assign bus.alusrca = alusrca;
  assign bus.alusrcb = alusrcb;
  assign bus.alucontrol = reset ? 4'b0000 : alu_ctl;
  assign bus.pcsrc = pcsrc;
  assign bus.illegal_op = illegal;
  assign bus.dbg_state = STATE_W'(state);
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: table-driven, directed and randomized checks of mips_mc_control
module tb_mips_mc_control;
  import mips_ctrl_pkg::*;
  typedef struct {
    int cyc;
    int rw;
    int pc;
    int mwc;
    int mrd;
    int ill;
    logic [3:0] aluc;
    logic [1:0] wsel;
    logic [63:0] tr;
  } res_t;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    int fw;
    int mw;
    res_t e;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  int total = 0;
  int passed = 0;
  logic [5:0] en0, en1;
  mips_mc_control_if #(.STATE_W(4)) b0 ();
  mips_mc_control_if #(.STATE_W(4)) b1 ();
  assign b0.opcode = opcode;
  assign b0.funct = funct;
  assign b0.zero = zero;
  assign b0.mem_ready = mem_ready;
  assign b1.opcode = opcode;
  assign b1.funct = funct;
  assign b1.zero = zero;
  assign b1.mem_ready = mem_ready;
  assign en0 = {b0.pcen, b0.memread, b0.memwrite, b0.irwrite, b0.regwrite, b0.illegal_op};
  assign en1 = {b1.pcen, b1.memread, b1.memwrite, b1.irwrite, b1.regwrite, b1.illegal_op};
  mips_mc_control #(.ILLEGAL_TRAP(1'b0), .STATE_W(4)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  mips_mc_control #(.ILLEGAL_TRAP(1'b1), .STATE_W(4)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Instruction-level reference: state walk and per-instruction totals from the documented rules
  function automatic res_t model(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
    res_t e;
    logic [3:0] q[$];
    e = '{default: 0};
    e.aluc = 4'hF;
    e.wsel = 2'b11;
    e.pc = 1;
    e.mrd = fw + 1;
    for (int i = 0; i <= fw; i++) q.push_back(4'd0);
    q.push_back(4'd1);
    case (op)
      OP_RTYPE:
        if (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}) begin
          q.push_back(4'd6);
          q.push_back(4'd7);
          e.rw = 1;
          e.wsel = 2'b10;
          e.aluc = fn == F_ADD ? 4'b0010 : fn == F_SUB ? 4'b0110 : fn == F_AND ? 4'b0000 :
                   fn == F_OR ? 4'b0001 : 4'b0111;
        end else e.ill = 1;
      OP_LW: begin
        q.push_back(4'd2);
        for (int i = 0; i <= mw; i++) q.push_back(4'd3);
        q.push_back(4'd4);
        e.rw = 1;
        e.wsel = 2'b01;
        e.mrd += mw + 1;
      end
      OP_SW: begin
        q.push_back(4'd2);
        for (int i = 0; i <= mw; i++) q.push_back(4'd5);
        e.mwc = mw + 1;
      end
      OP_BEQ: begin
        q.push_back(4'd8);
        e.aluc = 4'b0110;
        e.pc += int'(z);
      end
      OP_J: begin
        q.push_back(4'd11);
        e.pc = 2;
      end
      OP_ADDI: begin
        q.push_back(4'd9);
        q.push_back(4'd10);
        e.rw = 1;
        e.wsel = 2'b00;
      end
      default: e.ill = 1;
    endcase
    e.cyc = q.size();
    foreach (q[i]) e.tr = {e.tr[59:0], q[i]};
    return e;
  endfunction

  // Runs one instruction from FETCH back to FETCH, inserting fw fetch waits and mw memory waits
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw,
                     input int mw, output res_t r, output bit ok);
    int fc, mc;
    bit left;
    logic [3:0] st;
    r = '{default: 0};
    r.aluc = 4'hF;
    r.wsel = 2'b11;
    ok = 1'b0;
    fc = 0;
    mc = 0;
    left = 1'b0;
    opcode = op;
    funct = fn;
    zero = z;
    for (int k = 0; k < 64; k++) begin
      st = b0.dbg_state;
      if (left && st == 4'd0) begin
        ok = 1'b1;
        break;
      end
      if (st != 4'd0) left = 1'b1;
      if (st == 4'd0) begin
        mem_ready = fc >= fw;
        fc++;
      end else if (st == 4'd3 || st == 4'd5) begin
        mem_ready = mc >= mw;
        mc++;
      end else mem_ready = 1'b1;
      #1;
      r.cyc++;
      r.tr = {r.tr[59:0], st};
      r.rw += int'(b0.regwrite);
      r.pc += int'(b0.pcen);
      r.mwc += int'(b0.memwrite);
      r.mrd += int'(b0.memread);
      r.ill += int'(b0.illegal_op);
      if (st == 4'd6 || st == 4'd8) r.aluc = b0.alucontrol;
      if (b0.regwrite) r.wsel = {b0.regdst, b0.memtoreg};
      @(negedge clk);
    end
  endtask

  task automatic compare(input string tag, input res_t a, input res_t e, input bit ok);
    chk({tag, " done"}, 64'(ok), 64'd1);
    chk({tag, " cycles"}, 64'(a.cyc), 64'(e.cyc));
    chk({tag, " regwrites"}, 64'(a.rw), 64'(e.rw));
    chk({tag, " pcen"}, 64'(a.pc), 64'(e.pc));
    chk({tag, " memwrite"}, 64'(a.mwc), 64'(e.mwc));
    chk({tag, " memread"}, 64'(a.mrd), 64'(e.mrd));
    chk({tag, " illegal"}, 64'(a.ill), 64'(e.ill));
    chk({tag, " alucontrol"}, 64'(a.aluc), 64'(e.aluc));
    chk({tag, " wsel"}, 64'(a.wsel), 64'(e.wsel));
    chk({tag, " trace"}, a.tr, e.tr);
  endtask

  task automatic reset_both();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[16];
    res_t r, e;
    bit ok;
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    int mwcnt;
    tbl[0]  = '{OP_RTYPE, F_ADD, 1'b0, 0, 0, '{4, 1, 1, 0, 1, 0, 4'b0010, 2'b10, 64'h0167}};
    tbl[1]  = '{OP_RTYPE, F_SUB, 1'b0, 0, 0, '{4, 1, 1, 0, 1, 0, 4'b0110, 2'b10, 64'h0167}};
    tbl[2]  = '{OP_RTYPE, F_AND, 1'b1, 0, 0, '{4, 1, 1, 0, 1, 0, 4'b0000, 2'b10, 64'h0167}};
    tbl[3]  = '{OP_RTYPE, F_OR,  1'b0, 0, 0, '{4, 1, 1, 0, 1, 0, 4'b0001, 2'b10, 64'h0167}};
    tbl[4]  = '{OP_RTYPE, F_SLT, 1'b0, 0, 0, '{4, 1, 1, 0, 1, 0, 4'b0111, 2'b10, 64'h0167}};
    tbl[5]  = '{OP_LW,   6'd0, 1'b0, 0, 0, '{5, 1, 1, 0, 2, 0, 4'hF, 2'b01, 64'h01234}};
    tbl[6]  = '{OP_LW,   6'd0, 1'b0, 0, 3, '{8, 1, 1, 0, 5, 0, 4'hF, 2'b01, 64'h01233334}};
    tbl[7]  = '{OP_LW,   6'd0, 1'b0, 2, 0, '{7, 1, 1, 0, 4, 0, 4'hF, 2'b01, 64'h1234}};
    tbl[8]  = '{OP_SW,   6'd0, 1'b0, 0, 0, '{4, 0, 1, 1, 1, 0, 4'hF, 2'b11, 64'h0125}};
    tbl[9]  = '{OP_SW,   6'd0, 1'b0, 0, 2, '{6, 0, 1, 3, 1, 0, 4'hF, 2'b11, 64'h012555}};
    tbl[10] = '{OP_BEQ,  6'd0, 1'b1, 0, 0, '{3, 0, 2, 0, 1, 0, 4'b0110, 2'b11, 64'h018}};
    tbl[11] = '{OP_BEQ,  6'd0, 1'b0, 0, 0, '{3, 0, 1, 0, 1, 0, 4'b0110, 2'b11, 64'h018}};
    tbl[12] = '{OP_J,    6'd0, 1'b0, 0, 0, '{3, 0, 2, 0, 1, 0, 4'hF, 2'b11, 64'h01B}};
    tbl[13] = '{OP_ADDI, 6'd0, 1'b0, 0, 0, '{4, 1, 1, 0, 1, 0, 4'hF, 2'b00, 64'h019A}};
    tbl[14] = '{6'b111111, 6'd0, 1'b0, 0, 0, '{2, 0, 1, 0, 1, 1, 4'hF, 2'b11, 64'h01}};
    tbl[15] = '{OP_RTYPE, 6'b000001, 1'b0, 0, 0, '{2, 0, 1, 0, 1, 1, 4'hF, 2'b11, 64'h01}};
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'b111111, 6'b000011};
    fns = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b000001};
    reset = 1'b1;
    opcode = OP_RTYPE;
    funct = F_ADD;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset enables", 64'(en0), 64'd0);
      chk("reset enables trap", 64'(en1), 64'd0);
      chk("reset state", 64'(b0.dbg_state), 64'd0);
    end
    reset = 1'b0;
    #1;
    chk("first fetch enables", 64'({b0.memread, b0.irwrite, b0.pcen}), 64'b111);
    chk("first fetch alusrcb", 64'(b0.alusrcb), 64'b01);
    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].mw, r, ok);
      compare($sformatf("vec%0d", i), r, tbl[i].e, ok);
      if (tbl[i].e.ill != 0) reset_both();
    end
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      logic z;
      int fw, mw;
      op = ops[$urandom_range(0, 7)];
      fn = fns[$urandom_range(0, 5)];
      z = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      e = model(op, fn, z, fw, mw);
      run(op, fn, z, fw, mw, r, ok);
      compare($sformatf("rnd%0d op%02h fn%02h", n, op, fn), r, e, ok);
      if (e.ill != 0) reset_both();
    end
    opcode = 6'b111111;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("trap decode illegal", 64'({b0.illegal_op, b1.illegal_op}), 64'b11);
    chk("trap decode state", 64'(b1.dbg_state), 64'd1);
    @(negedge clk);
    #1;
    chk("nop next state", 64'(b0.dbg_state), 64'd0);
    chk("trap halt state", 64'(b1.dbg_state), 64'd12);
    chk("trap illegal pulse", 64'(b1.illegal_op), 64'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("halt enables %0d", k), 64'(en1), 64'd0);
      chk($sformatf("halt state %0d", k), 64'(b1.dbg_state), 64'd12);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("halt left by reset", 64'(b1.dbg_state), 64'd0);
    opcode = OP_SW;
    funct = 6'd0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sw in memwr", 64'(b0.dbg_state), 64'd5);
    chk("sw memwrite", 64'(b0.memwrite), 64'd1);
    @(negedge clk);
    #1;
    chk("sw memwrite held", 64'({b0.memwrite, b0.iord}), 64'b11);
    reset = 1'b1;
    #1;
    chk("sw reset drops enables", 64'(en0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    opcode = OP_RTYPE;
    funct = F_ADD;
    mem_ready = 1'b1;
    #1;
    chk("sw reset to fetch", 64'(b0.dbg_state), 64'd0);
    mwcnt = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      mwcnt += int'(b0.memwrite);
    end
    chk("sw memwrite not reasserted", 64'(mwcnt), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
